trdb_reg_multi: RTL



---
 rtl/trdb_pkg.sv | 56 +++++
 rtl/trdb_sw_fifo.sv | 79 +++++++
 rtl/trdb_reg_multi.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trdb_pkg.sv
// Shared register map, bit indices and decode types for the trace-debugger register file.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package trdb_pkg;

  localparam int unsigned TRDB_MAX_RANGES = 8;

  // Byte offsets of the fixed registers
  localparam int unsigned OFF_CTRL       = 32'h00;
  localparam int unsigned OFF_STATUS     = 32'h04;
  localparam int unsigned OFF_FILTER     = 32'h08;
  localparam int unsigned OFF_DUMP       = 32'h0C;
  localparam int unsigned OFF_DUMP_TIME  = 32'h10;
  localparam int unsigned OFF_SWFIFO     = 32'h14;
  localparam int unsigned OFF_RANGE_CTRL = 32'h18;
  localparam int unsigned OFF_RANGE_BASE = 32'h20;

  // CTRL bits
  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_ACTIVATED = 1;
  localparam int CTRL_CLEAR     = 2;
  localparam int CTRL_FLUSH     = 3;
  localparam int CTRL_FULL_ADDR = 4;

  // STATUS bits (0..2 are the registered live inputs)
  localparam int STAT_FIFO_OVF = 3;
  localparam int STAT_EXT_OVF  = 4;

  // FILTER bits
  localparam int FILT_APPLY = 0;
  localparam int FILT_PRIV  = 1;
  localparam int FILT_WHICH = 2;  // two bits wide

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_STATUS,
    SEL_FILTER,
    SEL_DUMP,
    SEL_DUMP_TIME,
    SEL_SWFIFO,
    SEL_RANGE_CTRL,
    SEL_LOWER,
    SEL_HIGHER
  } reg_sel_e;

  // Each range owns a LOWER/HIGHER pair, 8 bytes apart.
  function automatic int unsigned range_lo_off(input int unsigned idx);
    return OFF_RANGE_BASE + 8 * idx;
  endfunction

  function automatic int unsigned range_hi_off(input int unsigned idx);
    return OFF_RANGE_BASE + 8 * idx + 4;
  endfunction

endpackage

// File: rtl/trdb_sw_fifo.sv
// Software dump FIFO: DEPTH x WIDTH, synchronous clear, level/full/empty flags.
// Latency: push visible at head the cycle after acceptance; pop frees the slot next cycle.
// Backpressure: push ignored when full (registered level); clear drops contents but keeps a same-cycle push.
// Ports: clk_i/rst_i, clr_i, push_i/push_dat_i, pop_i, head_dat_o, level_o, empty_o, full_o.
module trdb_sw_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_dat_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o     = (level_q == LW'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign head_dat_o = mem_q[rptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (clr_i) begin
      // A push that lands together with clear becomes the sole entry.
      rptr_d  = '0;
      wptr_d  = '0;
      level_d = '0;
      if (do_push) begin
        mem_d[0] = push_dat_i;
        wptr_d   = AW'(1);
        level_d  = LW'(1);
      end
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = push_dat_i;
        wptr_d        = wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/trdb_reg_multi.sv
// APB control/status register file for the trace debugger with NUM_RANGES address filters and a sw dump FIFO.
// Latency: register writes reach outputs next cycle; reads are combinational; dump word valid one cycle after acceptance.
// Backpressure: per_ready_o drops only for a dump write while the dump FIFO is full.
// Ports: APB per_* slave; CTRL/FILTER/range outputs to encoder; status inputs; sw_* dump stream (valid/grant).
module trdb_reg_multi
  import trdb_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int XLEN           = 32,
  parameter int NUM_RANGES     = 4,
  parameter int SW_FIFO_DEPTH  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         per_valid_i,
  input  logic                         per_we_i,
  input  logic [APB_ADDR_WIDTH-1:0]    per_addr_i,
  input  logic [31:0]                  per_wdata_i,
  output logic [31:0]                  per_rdata_o,
  output logic                         per_ready_o,
  output logic                         trace_enable_o,
  output logic                         trace_activated_o,
  output logic                         trace_full_addr_o,
  output logic                         flush_stream_o,
  output logic                         clear_fifo_o,
  input  logic                         trace_req_deactivate_i,
  input  logic                         flush_confirm_i,
  output logic                         apply_filters_o,
  output logic                         trace_selected_priv_o,
  output logic [1:0]                   trace_which_priv_o,
  output logic [NUM_RANGES-1:0]        range_en_o,
  output logic [NUM_RANGES-1:0]        range_stop_o,
  output logic [NUM_RANGES*XLEN-1:0]   range_lo_o,
  output logic [NUM_RANGES*XLEN-1:0]   range_hi_o,
  input  logic                         trace_qualified_i,
  input  logic                         trace_priv_match_i,
  input  logic                         trace_range_match_i,
  input  logic                         trace_fifo_overflow_i,
  input  logic                         external_fifo_overflow_i,
  output logic [XLEN-1:0]              sw_word_o,
  output logic                         sw_valid_o,
  output logic                         sw_time_o,
  input  logic                         sw_grant_i
);

  localparam int RNG_W = $clog2(TRDB_MAX_RANGES);
  localparam int LVL_W = $clog2(SW_FIFO_DEPTH) + 1;

  // Register state
  logic                       enable_q, enable_d;
  logic                       activated_q, activated_d;
  logic                       clear_q, clear_d;
  logic                       flush_q, flush_d;
  logic                       full_addr_q, full_addr_d;
  logic [2:0]                 live_q, live_d;
  logic                       fifo_ovf_q, fifo_ovf_d;
  logic                       ext_ovf_q, ext_ovf_d;
  logic                       apply_q, apply_d;
  logic                       priv_q, priv_d;
  logic [1:0]                 which_q, which_d;
  logic [NUM_RANGES-1:0]      ren_q, ren_d;
  logic [NUM_RANGES-1:0]      rstop_q, rstop_d;
  logic [NUM_RANGES*XLEN-1:0] rlo_q, rlo_d;
  logic [NUM_RANGES*XLEN-1:0] rhi_q, rhi_d;

  reg_sel_e         sel;
  logic [RNG_W-1:0] rng_idx;
  logic             dump_sel, wr_en, fifo_full, fifo_empty;
  logic [XLEN:0]    fifo_head;
  logic [LVL_W-1:0] fifo_level;

  // Address decode
  always_comb begin
    sel     = SEL_NONE;
    rng_idx = '0;
    if      (per_addr_i == APB_ADDR_WIDTH'(OFF_CTRL))       sel = SEL_CTRL;
    else if (per_addr_i == APB_ADDR_WIDTH'(OFF_STATUS))     sel = SEL_STATUS;
    else if (per_addr_i == APB_ADDR_WIDTH'(OFF_FILTER))     sel = SEL_FILTER;
    else if (per_addr_i == APB_ADDR_WIDTH'(OFF_DUMP))       sel = SEL_DUMP;
    else if (per_addr_i == APB_ADDR_WIDTH'(OFF_DUMP_TIME))  sel = SEL_DUMP_TIME;
    else if (per_addr_i == APB_ADDR_WIDTH'(OFF_SWFIFO))     sel = SEL_SWFIFO;
    else if (per_addr_i == APB_ADDR_WIDTH'(OFF_RANGE_CTRL)) sel = SEL_RANGE_CTRL;
    for (int unsigned i = 0; i < NUM_RANGES; i++) begin
      if (per_addr_i == APB_ADDR_WIDTH'(range_lo_off(i))) begin
        sel     = SEL_LOWER;
        rng_idx = RNG_W'(i);
      end
      if (per_addr_i == APB_ADDR_WIDTH'(range_hi_off(i))) begin
        sel     = SEL_HIGHER;
        rng_idx = RNG_W'(i);
      end
    end
  end

  // Stall is judged on the registered level: a pop in the same cycle does not admit the push.
  assign dump_sel    = (sel == SEL_DUMP) || (sel == SEL_DUMP_TIME);
  assign per_ready_o = !(per_valid_i && per_we_i && dump_sel && fifo_full);
  assign wr_en       = per_valid_i && per_we_i && per_ready_o;

  always_comb begin
    enable_d    = enable_q;
    activated_d = activated_q;
    clear_d     = 1'b0;
    flush_d     = flush_q;
    full_addr_d = full_addr_q;
    live_d      = {trace_range_match_i, trace_priv_match_i, trace_qualified_i};
    fifo_ovf_d  = fifo_ovf_q;
    ext_ovf_d   = ext_ovf_q;
    apply_d     = apply_q;
    priv_d      = priv_q;
    which_d     = which_q;
    ren_d       = ren_q;
    rstop_d     = rstop_q;
    rlo_d       = rlo_q;
    rhi_d       = rhi_q;

    if (wr_en) begin
      case (sel)
        SEL_CTRL: begin
          enable_d    = per_wdata_i[CTRL_ENABLE];
          activated_d = per_wdata_i[CTRL_ACTIVATED];
          clear_d     = per_wdata_i[CTRL_CLEAR];
          flush_d     = per_wdata_i[CTRL_FLUSH];
          full_addr_d = per_wdata_i[CTRL_FULL_ADDR];
        end
        SEL_STATUS: begin
          if (per_wdata_i[STAT_FIFO_OVF]) fifo_ovf_d = 1'b0;
          if (per_wdata_i[STAT_EXT_OVF])  ext_ovf_d  = 1'b0;
        end
        SEL_FILTER: begin
          apply_d = per_wdata_i[FILT_APPLY];
          priv_d  = per_wdata_i[FILT_PRIV];
          which_d = per_wdata_i[FILT_WHICH +: 2];
        end
        SEL_RANGE_CTRL: begin
          ren_d   = per_wdata_i[0 +: NUM_RANGES];
          rstop_d = per_wdata_i[8 +: NUM_RANGES];
        end
        default: ;
      endcase
      for (int i = 0; i < NUM_RANGES; i++) begin
        if (rng_idx == RNG_W'(i)) begin
          if (sel == SEL_LOWER)  rlo_d[i*XLEN +: XLEN] = XLEN'(per_wdata_i);
          if (sel == SEL_HIGHER) rhi_d[i*XLEN +: XLEN] = XLEN'(per_wdata_i);
        end
      end
    end

    // Hardware events override software in the same cycle.
    if (trace_req_deactivate_i)   activated_d = 1'b0;
    if (flush_confirm_i)          flush_d     = 1'b0;
    if (trace_fifo_overflow_i)    fifo_ovf_d  = 1'b1;
    if (external_fifo_overflow_i) ext_ovf_d   = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_q    <= 1'b0;
      activated_q <= 1'b0;
      clear_q     <= 1'b0;
      flush_q     <= 1'b0;
      full_addr_q <= 1'b0;
      live_q      <= '0;
      fifo_ovf_q  <= 1'b0;
      ext_ovf_q   <= 1'b0;
      apply_q     <= 1'b0;
      priv_q      <= 1'b0;
      which_q     <= '0;
      ren_q       <= '0;
      rstop_q     <= '0;
      rlo_q       <= '0;
      rhi_q       <= '0;
    end else begin
      enable_q    <= enable_d;
      activated_q <= activated_d;
      clear_q     <= clear_d;
      flush_q     <= flush_d;
      full_addr_q <= full_addr_d;
      live_q      <= live_d;
      fifo_ovf_q  <= fifo_ovf_d;
      ext_ovf_q   <= ext_ovf_d;
      apply_q     <= apply_d;
      priv_q      <= priv_d;
      which_q     <= which_d;
      ren_q       <= ren_d;
      rstop_q     <= rstop_d;
      rlo_q       <= rlo_d;
      rhi_q       <= rhi_d;
    end
  end

  // Clear acts during the cycle clear_fifo_o is high, so a push stalled on full
  // is admitted the cycle after.
  trdb_sw_fifo #(
    .WIDTH (XLEN + 1),
    .DEPTH (SW_FIFO_DEPTH)
  ) u_sw_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (clear_q),
    .push_i     (wr_en && dump_sel),
    .push_dat_i ({sel == SEL_DUMP_TIME, XLEN'(per_wdata_i)}),
    .pop_i      (sw_valid_o && sw_grant_i),
    .head_dat_o (fifo_head),
    .level_o    (fifo_level),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  // Read mux
  always_comb begin
    per_rdata_o = '0;
    if (per_valid_i && !per_we_i) begin
      case (sel)
        SEL_CTRL:       per_rdata_o = {27'b0, full_addr_q, flush_q, clear_q, activated_q, enable_q};
        SEL_STATUS:     per_rdata_o = {27'b0, ext_ovf_q, fifo_ovf_q, live_q};
        SEL_FILTER:     per_rdata_o = {28'b0, which_q, priv_q, apply_q};
        SEL_SWFIFO:     per_rdata_o = {22'b0, fifo_full, fifo_empty, 8'(fifo_level)};
        SEL_RANGE_CTRL: per_rdata_o = (32'(rstop_q) << 8) | 32'(ren_q);
        default: ;
      endcase
      for (int i = 0; i < NUM_RANGES; i++) begin
        if (rng_idx == RNG_W'(i)) begin
          if (sel == SEL_LOWER)  per_rdata_o = 32'(rlo_q[i*XLEN +: XLEN]);
          if (sel == SEL_HIGHER) per_rdata_o = 32'(rhi_q[i*XLEN +: XLEN]);
        end
      end
    end
  end

  assign trace_enable_o        = enable_q;
  assign trace_activated_o     = activated_q;
  assign trace_full_addr_o     = full_addr_q;
  assign flush_stream_o        = flush_q;
  assign clear_fifo_o          = clear_q;
  assign apply_filters_o       = apply_q;
  assign trace_selected_priv_o = priv_q;
  assign trace_which_priv_o    = which_q;
  assign range_en_o            = ren_q;
  assign range_stop_o          = rstop_q;
  assign range_lo_o            = rlo_q;
  assign range_hi_o            = rhi_q;
  assign sw_valid_o            = !fifo_empty;
  assign sw_word_o             = fifo_head[XLEN-1:0];
  assign sw_time_o             = fifo_head[XLEN];

endmodule
